// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write-only LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  // Bit positions inside the processor LCD register.
  localparam int unsigned BIT_POWER  = 31;
  localparam int unsigned BIT_STROBE = 30;
  localparam int unsigned BIT_RS     = 9;
  localparam int unsigned DATA_MSB   = 7;

  // Default interface timing in clock cycles (50 MHz clock).
  localparam int unsigned DEF_T_SETUP = 2;
  localparam int unsigned DEF_T_EN    = 12;
  localparam int unsigned DEF_T_HOLD  = 2;
  localparam int unsigned DEF_T_EXEC  = 2000;
  localparam int unsigned DEF_T_LONG  = 82000;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter with zero flag, shared by every FSM state dwell.
module lcd_timer #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Load has priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: strobe-toggle requests, one-entry pending
// buffer, timed SETUP/EN/HOLD/EXEC sequence per transfer.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_EN    = DEF_T_EN,
  parameter int unsigned T_HOLD  = DEF_T_HOLD,
  parameter int unsigned T_EXEC  = DEF_T_EXEC,
  parameter int unsigned T_LONG  = DEF_T_LONG
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lcd_reg_i,
  output logic        lcd_busy_o,
  output logic        lcd_ovf_o,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o
);

  localparam int unsigned T_MAX =
    max_u(max_u(T_LONG, T_EXEC), max_u(T_EN, max_u(T_SETUP, T_HOLD)));
  localparam int unsigned TW = $clog2(T_MAX + 1);

  lcd_state_e state_q, state_d;
  logic       strobe_q;
  logic       pend_q, pend_d;
  logic       pend_rs_q, pend_rs_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       ovf_q, ovf_d;
  logic       en_q, busy_q, on_q;

  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_zero;

  logic       power, req, req_rs, buffer_req;
  logic [7:0] req_data;
  logic       unused_bits;

  assign power       = lcd_reg_i[BIT_POWER];
  assign req         = power && (lcd_reg_i[BIT_STROBE] != strobe_q);
  assign req_rs      = lcd_reg_i[BIT_RS];
  assign req_data    = lcd_reg_i[DATA_MSB:0];
  assign unused_bits = ^{lcd_reg_i[29:10], lcd_reg_i[8]};

  lcd_timer #(.WIDTH(TW)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load   (timer_load),
    .value  (timer_value),
    .zero   (timer_zero)
  );

  // Next-state, capture, pending-buffer and timer-load decisions.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    rs_d        = rs_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    timer_load  = 1'b0;
    timer_value = '0;
    buffer_req  = 1'b0;

    if (!power) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_d     = ST_SETUP;
            rs_d        = req_rs;
            data_d      = req_data;
            timer_load  = 1'b1;
            timer_value = TW'(T_SETUP - 1);
          end
        end
        ST_SETUP: begin
          buffer_req = 1'b1;
          if (timer_zero) begin
            state_d     = ST_EN_HI;
            timer_load  = 1'b1;
            timer_value = TW'(T_EN - 1);
          end
        end
        ST_EN_HI: begin
          buffer_req = 1'b1;
          if (timer_zero) begin
            state_d     = ST_HOLD;
            timer_load  = 1'b1;
            timer_value = TW'(T_HOLD - 1);
          end
        end
        ST_HOLD: begin
          buffer_req = 1'b1;
          if (timer_zero) begin
            state_d     = ST_EXEC;
            timer_load  = 1'b1;
            timer_value = is_long_cmd(rs_q, data_q) ? TW'(T_LONG - 1) : TW'(T_EXEC - 1);
          end
        end
        ST_EXEC: begin
          // On the last cycle the next transfer (pending first, else a fresh
          // request) starts without an idle bubble; a fresh request arriving
          // as the pending entry drains refills the buffer instead of
          // overflowing it.
          if (timer_zero) begin
            if (pend_q) begin
              state_d     = ST_SETUP;
              rs_d        = pend_rs_q;
              data_d      = pend_data_q;
              timer_load  = 1'b1;
              timer_value = TW'(T_SETUP - 1);
              pend_d      = req;
              if (req) begin
                pend_rs_d   = req_rs;
                pend_data_d = req_data;
              end
            end else if (req) begin
              state_d     = ST_SETUP;
              rs_d        = req_rs;
              data_d      = req_data;
              timer_load  = 1'b1;
              timer_value = TW'(T_SETUP - 1);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            buffer_req = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (buffer_req && req) begin
        if (!pend_q) begin
          pend_d      = 1'b1;
          pend_rs_d   = req_rs;
          pend_data_d = req_data;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // State and registered outputs, all derived from next-state values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      strobe_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      strobe_q    <= lcd_reg_i[BIT_STROBE];
      pend_q      <= pend_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      en_q        <= (state_d == ST_EN_HI);
      busy_q      <= (state_d != ST_IDLE) || pend_d;
      on_q        <= power;
    end
  end

  assign lcd_busy_o = busy_q;
  assign lcd_ovf_o  = ovf_q;
  assign lcd_on_o   = on_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign lcd_data_o = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: transfer-level reference model feeds an
// expected-pulse queue; a negedge monitor checks every EN pulse against it.
module tb_lcd_ctrl;

  localparam int TS = 2;
  localparam int TE = 12;
  localparam int TH = 2;
  localparam int TX = 60;
  localparam int TL = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] reg_v = '0;
  logic        lcd_busy_o, lcd_ovf_o, lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o;
  logic [7:0]  lcd_data_o;

  lcd_ctrl #(
    .T_SETUP (TS),
    .T_EN    (TE),
    .T_HOLD  (TH),
    .T_EXEC  (TX),
    .T_LONG  (TL)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .lcd_reg_i  (reg_v),
    .lcd_busy_o (lcd_busy_o),
    .lcd_ovf_o  (lcd_ovf_o),
    .lcd_on_o   (lcd_on_o),
    .lcd_rs_o   (lcd_rs_o),
    .lcd_rw_o   (lcd_rw_o),
    .lcd_en_o   (lcd_en_o),
    .lcd_data_o (lcd_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         start;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    edge_cnt = 0;

  // Reference model state (transfer granularity, not cycle FSM).
  int         busy_until = 0;
  bit         pend_v = 0;
  logic       pend_rs = 0;
  logic [7:0] pend_data = 0;
  bit         m_strobe = 0;
  bit         m_ovf = 0;
  bit         m_on = 0;
  int         abort_edge = -1;
  int         abort_rise = -1;

  function automatic void check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, want, edge_cnt);
    end
  endfunction

  function automatic int dur(input logic rs, input logic [7:0] d);
    return TS + TE + TH + ((!rs && d >= 8'h01 && d <= 8'h03) ? TL : TX);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    busy_until = 0;
    pend_v     = 0;
    m_strobe   = 0;
    m_ovf      = 0;
    m_on       = 0;
    abort_edge = -1;
  endfunction

  // Apply the request/power rules as seen by the controller at edge e.
  function automatic void model_edge(input int e);
    bit         power, req;
    logic       rs;
    logic [7:0] d;
    xfer_t      x;
    if (!rst_n) begin
      model_reset();
      return;
    end
    power    = reg_v[31];
    req      = power && (reg_v[30] != m_strobe);
    m_strobe = reg_v[30];
    m_on     = power;
    rs       = reg_v[9];
    d        = reg_v[7:0];
    if (!power) begin
      while (exp_q.size() > 0 && exp_q[$].start + TS + TE > e) begin
        if (exp_q[$].start + TS <= e - 1) begin
          abort_edge = e;
          abort_rise = exp_q[$].start + TS;
        end
        void'(exp_q.pop_back());
      end
      if (busy_until > e) busy_until = e;
      pend_v = 0;
      return;
    end
    if (pend_v && e >= busy_until) begin
      busy_until = e + dur(pend_rs, pend_data);
      pend_v     = 0;
    end
    if (req) begin
      if (e >= busy_until) begin
        x = '{rs: rs, data: d, start: e};
        exp_q.push_back(x);
        busy_until = e + dur(rs, d);
      end else if (!pend_v) begin
        x = '{rs: rs, data: d, start: busy_until};
        exp_q.push_back(x);
        pend_v    = 1;
        pend_rs   = rs;
        pend_data = d;
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    model_edge(edge_cnt);
    #1;
    check("busy", int'(lcd_busy_o), int'((edge_cnt < busy_until) || pend_v));
    check("ovf", int'(lcd_ovf_o), int'(m_ovf));
    check("on", int'(lcd_on_o), int'(m_on));
    check("rw", int'(lcd_rw_o), 0);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    reg_v[31]  = 1'b1;
    reg_v[30]  = ~reg_v[30];
    reg_v[9]   = rs;
    reg_v[7:0] = d;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!lcd_busy_o && !((edge_cnt < busy_until) || pend_v)) break;
      tick();
    end
    check("idle_timeout", int'(lcd_busy_o), 0);
  endtask

  task automatic busy_len(input string name, input int want);
    int cnt;
    cnt = 0;
    tick();
    while (lcd_busy_o && cnt < 5000) begin
      cnt++;
      tick();
    end
    check(name, cnt, want);
  endtask

  // Monitor: every completed EN pulse is matched against the expected queue.
  logic       prev_en = 1'b0;
  int         rise_e = 0;
  logic       rise_rs = 1'b0;
  logic [7:0] rise_data = '0;
  xfer_t      got;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (lcd_en_o && !prev_en) begin
        rise_e    = edge_cnt;
        rise_rs   = lcd_rs_o;
        rise_data = lcd_data_o;
      end else if (!lcd_en_o && prev_en) begin
        if (edge_cnt == abort_edge) begin
          check("abort_rise", rise_e, abort_rise);
          abort_edge = -1;
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_en: pulse rose at edge %0d data %0h, none expected", rise_e, rise_data);
        end else begin
          got = exp_q.pop_front();
          check("en_rise_edge", rise_e, got.start + TS);
          check("en_width", edge_cnt - rise_e, TE);
          check("rs_at_rise", int'(rise_rs), int'(got.rs));
          check("data_at_rise", int'(rise_data), int'(got.data));
          check("data_at_fall", int'(lcd_data_o), int'(got.data));
          check("rs_at_fall", int'(lcd_rs_o), int'(got.rs));
        end
      end
      prev_en = lcd_en_o;
    end
  end

  initial begin
    int cnt;

    // Reset with power on and strobe bit set: release yields one request.
    reg_v = 32'h0;
    reg_v[31] = 1'b1;
    reg_v[30] = 1'b1;
    reg_v[9] = 1'b1;
    reg_v[7:0] = 8'h55;
    repeat (3) tick();
    check("rst_en", int'(lcd_en_o), 0);
    check("rst_data", int'(lcd_data_o), 0);
    check("rst_rs", int'(lcd_rs_o), 0);
    #2 rst_n = 1'b1;
    busy_len("release_busy_len", TS + TE + TH + TX);
    wait_idle(100);

    // Single data write.
    send(1'b1, 8'h41);
    busy_len("single_busy_len", TS + TE + TH + TX);
    check("single_ovf", int'(lcd_ovf_o), 0);

    // Clear display uses the long wait.
    send(1'b0, 8'h01);
    busy_len("clear_busy_len", TS + TE + TH + TL);
    check("clear_ovf", int'(lcd_ovf_o), 0);

    // Return home (0x02) long, 0x04 normal.
    send(1'b0, 8'h02);
    busy_len("home_busy_len", TS + TE + TH + TL);
    send(1'b0, 8'h04);
    busy_len("cmd04_busy_len", TS + TE + TH + TX);

    // Back-to-back: third request is dropped.
    send(1'b1, 8'h41);
    repeat (5) tick();
    send(1'b1, 8'h42);
    repeat (5) tick();
    send(1'b1, 8'h43);
    wait_idle(500);
    check("b2b_ovf", int'(lcd_ovf_o), 1);

    // Power-off abort during EN high.
    send(1'b1, 8'h30);
    cnt = 0;
    while (!lcd_en_o && cnt < 20) begin
      cnt++;
      tick();
    end
    check("abort_en_seen", int'(lcd_en_o), 1);
    repeat (3) tick();
    reg_v[31] = 1'b0;
    tick();
    check("abort_en_low", int'(lcd_en_o), 0);
    check("abort_busy_low", int'(lcd_busy_o), 0);
    check("abort_on_low", int'(lcd_on_o), 0);
    repeat (10) tick();
    reg_v[30] = ~reg_v[30];
    repeat (10) tick();
    reg_v[31] = 1'b1;
    repeat (40) tick();
    check("abort_no_restart", int'(lcd_busy_o), 0);

    // Async reset in EXEC with pending full.
    send(1'b1, 8'h61);
    repeat (5) tick();
    send(1'b1, 8'h62);
    repeat (20) tick();
    check("pre_reset_busy", int'(lcd_busy_o), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_busy", int'(lcd_busy_o), 0);
    check("async_ovf", int'(lcd_ovf_o), 0);
    check("async_on", int'(lcd_on_o), 0);
    check("async_rs", int'(lcd_rs_o), 0);
    check("async_en", int'(lcd_en_o), 0);
    check("async_data", int'(lcd_data_o), 0);
    reg_v[30] = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (40) tick();
    check("post_reset_idle", int'(lcd_busy_o), 0);

    // Randomised traffic, register noise and occasional power drops.
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      logic [7:0] d;
      r = $urandom_range(0, 999);
      if (!reg_v[31]) begin
        if ($urandom_range(0, 4) == 0) reg_v[31] = 1'b1;
      end else if (r < 3) begin
        reg_v[31] = 1'b0;
      end else if (r < 20) begin
        d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
        send(1'($urandom_range(0, 1)), d);
      end else if (r < 300) begin
        reg_v[9]   = 1'($urandom_range(0, 1));
        reg_v[7:0] = 8'($urandom_range(0, 255));
        reg_v[20]  = 1'($urandom_range(0, 1));
      end
      tick();
    end

    reg_v[31] = 1'b1;
    wait_idle(2000);
    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
